fpu_addsub_sched: RTL
=====================

// Module: fpu_addsub_sched
// PURPOSE
//  Round-robin scheduler sharing one bfloat16 Add_Sub datapath between NUM_REQ requesters.
//  - Accepts one add/sub request per grant and registers its operands into Add_Sub.
//  - Returns the registered result with the requester ID over a valid/ready response port.
//  - Sits between the core-side FPU request ports and the single Add_Sub instance.
// PARAMETERS
//  NUM_REQ  4                    number of requesters (2..8)
//  ID_W     $clog2(NUM_REQ)      width of requester ID
// PORTS
//  clk_i        in   1           clock
//  rst_ni       in   1           synchronous reset, active-low
//  req_valid_i  in   NUM_REQ     per-requester request valid
//  req_ready_o  out  NUM_REQ     per-requester accept (one-hot or zero)
//  req_op_i     in   NUM_REQ     per-requester op: 0 = add, 1 = subtract (A-B)
//  req_a_i      in   16*NUM_REQ  operand A, bf16; requester k in bits [16k+15:16k]
//  req_b_i      in   16*NUM_REQ  operand B, bf16; same packing
//  rsp_valid_o  out  1           result valid
//  rsp_ready_i  in   1           result consumer ready
//  rsp_data_o   out  16          result C, bf16
//  rsp_id_o     out  ID_W        index of requester owning rsp_data_o
// BEHAVIOUR
//  - FSM states: IDLE, EXEC, RESP. Reset: state=IDLE, rr_ptr=0, rsp_valid_o=0, rsp_data_o=0,
//    rsp_id_o=0, operand regs=0. req_ready_o is combinational and is 0 whenever rst_ni=0.
//  - Accept window: state==IDLE, or state==RESP && rsp_ready_i.
//  - Grant: in the accept window, grant the first valid requester scanning rr_ptr, rr_ptr+1, ...
//    modulo NUM_REQ. req_ready_o[g]=1 for the granted requester only; all others 0.
//  - Accept edge: capture op/A/B and ID g into operand regs; rr_ptr <= (g+1) mod NUM_REQ; next=EXEC.
//  - EXEC: Add_Sub operates combinationally on the operand regs. On the next edge, latch
//    C into rsp_data_o and the ID into rsp_id_o; next=RESP.
//  - RESP: rsp_valid_o=1, data and ID held stable until rsp_ready_i=1.
//    rsp_ready_i=1 with an accept: next=EXEC. rsp_ready_i=1 without an accept: next=IDLE.
//  - Latency: accept edge to rsp_valid_o high is 2 cycles. Max throughput is 1 op per 2 cycles.
//  - Requesters hold valid, op and operands stable until ready. Dropping valid before ready is legal;
//    the request is simply not taken. req_ready_o may depend combinationally on req_valid_i.
//  - No valid requests in the accept window: rr_ptr unchanged, FSM stays in or moves to IDLE.
//  - rr_ptr wraps from NUM_REQ-1 to 0. With all requesters valid, grants go 0,1,...,NUM_REQ-1,0.
//  - Reset mid-operation (EXEC or RESP): the in-flight result is discarded and every register
//    returns to its reset value on that edge.
//  - Arithmetic, rounding and special values come from Add_Sub. This block never alters C.
// CONFIGURATION
//  FPU_SCHED_STATS_EN defined: adds outputs stat_ops_o[31:0] and stat_stall_o[31:0].
//   - stat_ops_o counts completed response handshakes.
//   - stat_stall_o counts cycles with rsp_valid_o && !rsp_ready_i.
//   - Both saturate at 32'hFFFF_FFFF and reset to 0.
//  FPU_SCHED_STATS_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  fpu_pkg: bf16_t (16-bit), OP_ADD=1'b0 / OP_SUB=1'b1, FSM state enum.
//  Sub-module rr_arbiter (NUM_REQ): inputs valid vector, ptr, enable; outputs one-hot grant and index.
//  Add_Sub instantiated as-is: operator_i <- op reg, A/B <- operand regs, C -> result latch.
// TESTING
//  1 Req0 add A=16'h3F80, B=16'h4000, rsp_ready_i=1 -> rsp_valid_o 2 cycles after accept,
//    rsp_data_o=16'h4040, rsp_id_o=0.
//  2 Req2 sub A=16'h4040, B=16'h3F80 -> rsp_data_o=16'h4000, rsp_id_o=2.
//  3 All 4 requesters valid continuously -> grant order 0,1,2,3,0, one accept every 2 cycles.
//  4 rsp_ready_i=0 for 5 cycles in RESP -> data/ID stable, req_ready_o=0, no accept;
//    ready=1 -> handshake and same-cycle accept of the next request.
//  5 rst_ni=0 during EXEC -> next cycle IDLE, rsp_valid_o=0, rr_ptr=0, no response emitted.
//  6 FPU_SCHED_STATS_EN: 3 ops with 4 total stall cycles -> stat_ops_o=3, stat_stall_o=4.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types for the bfloat16 add/sub scheduler.
//   bf16_t   : raw bfloat16 bit pattern
//   OP_ADD/OP_SUB : operator encoding carried on req_op_i / Add_Sub.operator_i
//   state_t  : scheduler FSM states
package fpu_pkg;

    typedef logic [15:0] bf16_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

endpackage

// File: rtl/Add_Sub.sv
// Combinational bfloat16 adder/subtractor, round-to-nearest-even.
// Subnormal inputs and results are flushed to signed zero; exact
// cancellation gives +0; NaN results are the canonical 16'h7FC0.
// Ports:
//   operator_i  0 = A+B, 1 = A-B
//   A, B        bf16 operands
//   C           bf16 result
module Add_Sub
    import fpu_pkg::*;
(
    input  logic  operator_i,
    input  bf16_t A,
    input  bf16_t B,
    output bf16_t C
);

    logic              w_sb, w_swap, w_sx, w_sy;
    logic [7:0]        w_ex, w_ey, w_diff, w_mx, w_my;
    logic [25:0]       w_yfull, w_ysh, w_lost;
    logic [26:0]       w_xal, w_yal, w_sum, w_norm;
    logic [4:0]        w_lz;
    logic signed [9:0] w_exp, w_exp_r;
    logic [7:0]        w_frac;
    logic              w_rnd, w_a_nan, w_b_nan, w_a_inf, w_b_inf;

    // Effective sign of B, then order operands so |X| >= |Y|.
    assign w_sb   = B[15] ^ (operator_i == OP_SUB);
    assign w_swap = B[14:0] > A[14:0];
    assign w_sx   = w_swap ? w_sb : A[15];
    assign w_sy   = w_swap ? A[15] : w_sb;
    assign w_ex   = w_swap ? B[14:7] : A[14:7];
    assign w_ey   = w_swap ? A[14:7] : B[14:7];
    assign w_mx   = (w_ex == 8'd0) ? 8'd0 : {1'b1, (w_swap ? B[6:0] : A[6:0])};
    assign w_my   = (w_ey == 8'd0) ? 8'd0 : {1'b1, (w_swap ? A[6:0] : B[6:0])};
    assign w_diff = w_ex - w_ey;

    // 18 fraction bits below the mantissa; bits shifted further out are
    // jammed into the LSB as sticky, which keeps RNE exact.
    assign w_yfull = {w_my, 18'd0};
    assign w_ysh   = w_yfull >> w_diff;
    assign w_lost  = w_yfull & ~({26{1'b1}} << w_diff);
    assign w_xal   = {1'b0, w_mx, 18'd0};
    assign w_yal   = {1'b0, w_ysh[25:1], w_ysh[0] | (|w_lost)};
    assign w_sum   = (w_sx == w_sy) ? w_xal + w_yal : w_xal - w_yal;

    // Leading-zero count from bit 26 (the carry position).
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (w_sum[i]) w_lz = 5'(26 - i);
    end

    assign w_norm  = w_sum << w_lz;
    assign w_exp   = $signed({2'b00, w_ex}) + 10'sd1 - $signed({5'd0, w_lz});
    assign w_rnd   = w_norm[18] & ((|w_norm[17:0]) | w_norm[19]);
    // frac[7] is the carry out of rounding (mantissa 1.111.. -> 10.000..)
    assign w_frac  = {1'b0, w_norm[25:19]} + {7'd0, w_rnd};
    assign w_exp_r = w_exp + $signed({9'd0, w_frac[7]});

    assign w_a_nan = (A[14:7] == 8'hFF) && (A[6:0] != 7'd0);
    assign w_b_nan = (B[14:7] == 8'hFF) && (B[6:0] != 7'd0);
    assign w_a_inf = (A[14:7] == 8'hFF) && (A[6:0] == 7'd0);
    assign w_b_inf = (B[14:7] == 8'hFF) && (B[6:0] == 7'd0);

    always_comb begin
        C = 16'h0000;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (A[15] != w_sb)))
            C = 16'h7FC0;
        else if (w_a_inf)
            C = {A[15], 15'h7F80};
        else if (w_b_inf)
            C = {w_sb, 15'h7F80};
        else if (!w_norm[26])
            C = 16'h0000;                       // exact zero
        else if (w_exp_r > 10'sd254)
            C = {w_sx, 15'h7F80};               // overflow to inf
        else if (w_exp_r < 10'sd1)
            C = {w_sx, 15'h0000};               // flush underflow
        else
            C = {w_sx, w_exp_r[7:0], (w_frac[7] ? 7'd0 : w_frac[6:0])};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester scanning from i_ptr
// upwards, modulo NUM_REQ.
// Ports:
//   i_valid [NUM_REQ] request vector
//   i_ptr   [ID_W]    highest-priority index this cycle
//   i_en              arbitration enabled (grant forced to zero when low)
//   o_gnt   [NUM_REQ] one-hot grant (or zero)
//   o_idx   [ID_W]    index of granted requester
//   o_any             a grant was issued
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_en && !o_any && i_valid[(int'(i_ptr) + i) % NUM_REQ]) begin
                o_any = 1'b1;
                o_idx = ID_W'((int'(i_ptr) + i) % NUM_REQ);
                o_gnt[(int'(i_ptr) + i) % NUM_REQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_sched.sv
// Round-robin scheduler sharing one bf16 Add_Sub between NUM_REQ requesters.
// One request is accepted per grant, its operands registered into Add_Sub,
// and the result returned with the requester ID over a valid/ready port.
// Optional statistics counters are built when FPU_SCHED_STATS_EN is defined.
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   req_valid_i/req_ready_o   per-requester handshake (ready one-hot or zero)
//   req_op_i                  per-requester op (0 add, 1 sub)
//   req_a_i/req_b_i           bf16 operands, requester k at [16k+15:16k]
//   rsp_valid_o/rsp_ready_i   result handshake
//   rsp_data_o, rsp_id_o      result and owning requester
//   stat_ops_o, stat_stall_o  (FPU_SCHED_STATS_EN only) handshake / stall counts
module fpu_addsub_sched
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [NUM_REQ-1:0]   req_op_i,
    input  logic [16*NUM_REQ-1:0] req_a_i,
    input  logic [16*NUM_REQ-1:0] req_b_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [15:0]          rsp_data_o,
    output logic [ID_W-1:0]      rsp_id_o
`ifdef FPU_SCHED_STATS_EN
   ,output logic [31:0]          stat_ops_o,
    output logic [31:0]          stat_stall_o
`endif
);

    state_t            r_state;
    logic [ID_W-1:0]   r_ptr, r_id, r_rsp_id;
    logic              r_op, r_rsp_valid;
    bf16_t             r_a, r_b, r_rsp_data;

    logic              w_win, w_gany;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]   w_gidx;
    bf16_t             w_c;

    // Accept window; gating with rst_ni keeps req_ready_o low during reset.
    assign w_win = rst_ni && ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready_i));

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .i_valid (req_valid_i),
        .i_ptr   (r_ptr),
        .i_en    (w_win),
        .o_gnt   (w_gnt),
        .o_idx   (w_gidx),
        .o_any   (w_gany)
    );

    Add_Sub u_addsub (
        .operator_i (r_op),
        .A          (r_a),
        .B          (r_b),
        .C          (w_c)
    );

    assign req_ready_o = w_gnt;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_id_o    = r_rsp_id;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_op        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            // w_gany can only be set inside the accept window.
            if (w_gany) begin
                r_op  <= req_op_i[w_gidx];
                r_a   <= req_a_i[32'(w_gidx)*16 +: 16];
                r_b   <= req_b_i[32'(w_gidx)*16 +: 16];
                r_id  <= w_gidx;
                r_ptr <= (w_gidx == ID_W'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
            end
            case (r_state)
                S_IDLE: if (w_gany) r_state <= S_EXEC;
                S_EXEC: begin
                    r_rsp_data  <= w_c;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: if (rsp_ready_i) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= w_gany ? S_EXEC : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FPU_SCHED_STATS_EN
    logic [31:0] r_stat_ops, r_stat_stall;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stat_ops   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (r_rsp_valid && rsp_ready_i && (r_stat_ops != 32'hFFFF_FFFF))
                r_stat_ops <= r_stat_ops + 32'd1;
            if (r_rsp_valid && !rsp_ready_i && (r_stat_stall != 32'hFFFF_FFFF))
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_ops_o   = r_stat_ops;
    assign stat_stall_o = r_stat_stall;
`endif

endmodule
